// File: rtl/axist_test_csr_pkg.sv
// Shared definitions for the AXI4-ST test CSR block: register map, bit positions
// and run-sequencer states.
package axist_test_csr_pkg;

  localparam logic [15:0] OFF_ID         = 16'h0000;
  localparam logic [15:0] OFF_CTRL       = 16'h0004;
  localparam logic [15:0] OFF_NUM_PKTS   = 16'h0008;
  localparam logic [15:0] OFF_PAT_SEED   = 16'h000C;
  localparam logic [15:0] OFF_STATUS     = 16'h0010;
  localparam logic [15:0] OFF_TX_CNT     = 16'h0014;
  localparam logic [15:0] OFF_RX_CNT     = 16'h0018;
  localparam logic [15:0] OFF_ERR_CNT    = 16'h001C;
  localparam logic [15:0] OFF_RUN_CYCLES = 16'h0020;
  localparam logic [15:0] OFF_SCRATCH    = 16'h0024;

  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_CONT  = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hBADA_DD00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } run_state_e;

endpackage

// File: rtl/axist_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module axist_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axist_test_csr.sv
// Register bank and run sequencer for the AXI4-ST traffic generator/checker,
// fed by the JTAG-to-AVMM offset decode; reads return one cycle after rd_en.
module axist_test_csr
  import axist_test_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'hA1B5_0001,
  parameter int          CNT_W        = 32,
  parameter logic [15:0] NUM_PKTS_RST = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] wr_rd_addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_datain,
  output logic        rd_dvalid,
  output logic        start_o,
  output logic        stop_o,
  output logic        loopback_o,
  output logic        cont_o,
  output logic [15:0] num_pkts_o,
  output logic [31:0] seed_o,
  input  logic        tx_pkt_i,
  input  logic        rx_pkt_i,
  input  logic        err_i,
  input  logic        done_i
);

  run_state_e state_q;
  logic       start_q, stop_q;
  logic       ctrl_loop_q, ctrl_cont_q;
  logic [15:0] num_pkts_q;
  logic [31:0] seed_q, scratch_q;
  logic       sts_done_q, sts_done_d;
  logic       sts_err_q, sts_err_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic       rd_vld_q;
  logic [31:0] rd_mux;

  logic wr_ctrl, wr_num_pkts, wr_seed, wr_status, wr_scratch;
  logic start_fire, stop_fire, run_active;

  logic [CNT_W-1:0] tx_cnt, rx_cnt, err_cnt, run_cnt;

  // Exact offset match also rejects misaligned addresses.
  assign wr_ctrl     = wr_en && (wr_rd_addr == OFF_CTRL);
  assign wr_num_pkts = wr_en && (wr_rd_addr == OFF_NUM_PKTS);
  assign wr_seed     = wr_en && (wr_rd_addr == OFF_PAT_SEED);
  assign wr_status   = wr_en && (wr_rd_addr == OFF_STATUS);
  assign wr_scratch  = wr_en && (wr_rd_addr == OFF_SCRATCH);

  assign run_active = (state_q != ST_IDLE);
  assign start_fire = wr_ctrl && wr_data[CTRL_START] && (state_q == ST_IDLE);
  // A done_i arriving with the STOP write ends the run without a stop pulse.
  assign stop_fire  = wr_ctrl && wr_data[CTRL_STOP] && (state_q == ST_RUN) && !done_i;

  axist_sat_counter #(.CNT_W(CNT_W)) u_tx_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(start_fire), .inc_i(tx_pkt_i), .cnt_o(tx_cnt)
  );
  axist_sat_counter #(.CNT_W(CNT_W)) u_rx_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(start_fire), .inc_i(rx_pkt_i), .cnt_o(rx_cnt)
  );
  axist_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(start_fire), .inc_i(err_i), .cnt_o(err_cnt)
  );
  axist_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(start_fire), .inc_i(run_active), .cnt_o(run_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_fire) begin
            state_q <= ST_RUN;
            start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (done_i) begin
            state_q <= ST_IDLE;
          end else if (stop_fire) begin
            state_q <= ST_STOPPING;
            stop_q  <= 1'b1;
          end
        end
        ST_STOPPING: begin
          if (done_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky status: a set in the same cycle as a W1C wins.
  always_comb begin
    sts_done_d = sts_done_q;
    if (start_fire) begin
      sts_done_d = 1'b0;
    end else if (done_i && run_active) begin
      sts_done_d = 1'b1;
    end else if (wr_status && wr_data[STATUS_DONE]) begin
      sts_done_d = 1'b0;
    end

    sts_err_d = sts_err_q;
    if (err_i) begin
      sts_err_d = 1'b1;
    end else if (wr_status && wr_data[STATUS_ERR]) begin
      sts_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_loop_q <= 1'b0;
      ctrl_cont_q <= 1'b0;
      num_pkts_q  <= NUM_PKTS_RST;
      seed_q      <= '0;
      scratch_q   <= '0;
      sts_done_q  <= 1'b0;
      sts_err_q   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_loop_q <= wr_data[CTRL_LOOP];
        ctrl_cont_q <= wr_data[CTRL_CONT];
      end
      if (wr_num_pkts) num_pkts_q <= wr_data[15:0];
      if (wr_seed)     seed_q     <= wr_data;
      if (wr_scratch)  scratch_q  <= wr_data;
      sts_done_q <= sts_done_d;
      sts_err_q  <= sts_err_d;
    end
  end

  always_comb begin
    rd_mux = UNMAPPED_RDATA;
    case (wr_rd_addr)
      OFF_ID:         rd_mux = ID_VALUE;
      OFF_CTRL:       rd_mux = {29'd0, ctrl_cont_q, ctrl_loop_q, 1'b0};
      OFF_NUM_PKTS:   rd_mux = {16'd0, num_pkts_q};
      OFF_PAT_SEED:   rd_mux = seed_q;
      OFF_STATUS:     rd_mux = {29'd0, sts_err_q, sts_done_q, run_active};
      OFF_TX_CNT:     rd_mux = 32'(tx_cnt);
      OFF_RX_CNT:     rd_mux = 32'(rx_cnt);
      OFF_ERR_CNT:    rd_mux = 32'(err_cnt);
      OFF_RUN_CYCLES: rd_mux = 32'(run_cnt);
      OFF_SCRATCH:    rd_mux = scratch_q;
      default:        rd_mux = UNMAPPED_RDATA;
    endcase
    rd_data_d = rd_en ? rd_mux : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_en;
    end
  end

  assign rd_datain  = rd_data_q;
  assign rd_dvalid  = rd_vld_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign loopback_o = ctrl_loop_q;
  assign cont_o     = ctrl_cont_q;
  assign num_pkts_o = num_pkts_q;
  assign seed_o     = seed_q;

endmodule

// File: tb/tb_axist_test_csr.sv
// Bench for axist_test_csr: two instances (32-bit and 4-bit counters) driven in
// lockstep and compared every cycle against a behavioural register-map model.
module tb_axist_test_csr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        tx = 1'b0, rx = 1'b0, err = 1'b0, done = 1'b0;

  logic [31:0] a_rd, b_rd, a_seed, b_seed;
  logic        a_dv, b_dv, a_start, b_start, a_stop, b_stop;
  logic        a_loop, b_loop, a_cont, b_cont;
  logic [15:0] a_npk, b_npk;

  int checks = 0;
  int errors = 0;
  int cycnum = 0;
  int nstart = 0;
  int nstop = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  axist_test_csr #(.CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_rd_addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_data(wdata), .rd_datain(a_rd), .rd_dvalid(a_dv), .start_o(a_start),
    .stop_o(a_stop), .loopback_o(a_loop), .cont_o(a_cont), .num_pkts_o(a_npk),
    .seed_o(a_seed), .tx_pkt_i(tx), .rx_pkt_i(rx), .err_i(err), .done_i(done)
  );

  axist_test_csr #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_rd_addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_data(wdata), .rd_datain(b_rd), .rd_dvalid(b_dv), .start_o(b_start),
    .stop_o(b_stop), .loopback_o(b_loop), .cont_o(b_cont), .num_pkts_o(b_npk),
    .seed_o(b_seed), .tx_pkt_i(tx), .rx_pkt_i(rx), .err_i(err), .done_i(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cycnum);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;
  int              m_state;
  bit              m_loop, m_cont, m_done, m_err;
  bit [15:0]       m_npk;
  bit [31:0]       m_seed, m_scr;
  longint unsigned m_tx, m_rx, m_ec, m_rc;
  bit              e_dv, e_start, e_stop;
  bit [31:0]       e_rd_a, e_rd_b;
  bit              sf, pf, ctrlw, stw;

  function automatic bit [31:0] sat(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    if (v > mx) v = mx;
    return v[31:0];
  endfunction

  function automatic bit [31:0] mread(input bit [15:0] a, input int w);
    case (a)
      16'h0000: return 32'hA1B5_0001;
      16'h0004: return {29'd0, m_cont, m_loop, 1'b0};
      16'h0008: return {16'd0, m_npk};
      16'h000C: return m_seed;
      16'h0010: return {29'd0, m_err, m_done, (m_state != M_IDLE)};
      16'h0014: return sat(m_tx, w);
      16'h0018: return sat(m_rx, w);
      16'h001C: return sat(m_ec, w);
      16'h0020: return sat(m_rc, w);
      16'h0024: return m_scr;
      default:  return 32'hBADA_DD00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = M_IDLE; m_loop = 0; m_cont = 0; m_done = 0; m_err = 0;
      m_npk = 16'd16; m_seed = 0; m_scr = 0;
      m_tx = 0; m_rx = 0; m_ec = 0; m_rc = 0;
      e_dv = 0; e_start = 0; e_stop = 0; e_rd_a = 0; e_rd_b = 0;
    end else begin
      e_dv   = rd_en;
      e_rd_a = rd_en ? mread(addr, 32) : 32'd0;
      e_rd_b = rd_en ? mread(addr, 4) : 32'd0;
      ctrlw  = wr_en && (addr == 16'h0004);
      stw    = wr_en && (addr == 16'h0010);
      sf     = ctrlw && wdata[0] && (m_state == M_IDLE);
      pf     = ctrlw && wdata[3] && (m_state == M_RUN) && !done;
      e_start = sf;
      e_stop  = pf;
      if (sf) begin
        m_tx = 0; m_rx = 0; m_ec = 0; m_rc = 0;
      end else begin
        m_tx += tx; m_rx += rx; m_ec += err;
        if (m_state != M_IDLE) m_rc++;
      end
      if (sf) m_done = 0;
      else if (done && m_state != M_IDLE) m_done = 1;
      else if (stw && wdata[1]) m_done = 0;
      if (err) m_err = 1;
      else if (stw && wdata[2]) m_err = 0;
      if (ctrlw) begin m_loop = wdata[1]; m_cont = wdata[2]; end
      if (wr_en && addr == 16'h0008) m_npk = wdata[15:0];
      if (wr_en && addr == 16'h000C) m_seed = wdata;
      if (wr_en && addr == 16'h0024) m_scr = wdata;
      if (sf) m_state = M_RUN;
      else if (m_state != M_IDLE && done) m_state = M_IDLE;
      else if (pf) m_state = M_STOP;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_dvalid_a", 64'(a_dv), 64'(e_dv));
      chk("rd_dvalid_b", 64'(b_dv), 64'(e_dv));
      chk("rd_datain_a", 64'(a_rd), 64'(e_rd_a));
      chk("rd_datain_b", 64'(b_rd), 64'(e_rd_b));
      chk("start_o", 64'({a_start, b_start}), 64'({e_start, e_start}));
      chk("stop_o", 64'({a_stop, b_stop}), 64'({e_stop, e_stop}));
      chk("cfg_a", 64'({a_loop, a_cont, a_npk, a_seed}), 64'({m_loop, m_cont, m_npk, m_seed}));
      chk("cfg_b", 64'({b_loop, b_cont, b_npk, b_seed}), 64'({m_loop, m_cont, m_npk, m_seed}));
      if (a_start === 1'b1) nstart++;
      if (a_stop === 1'b1) nstop++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cycnum++;
  endtask

  task automatic wr(input bit [15:0] a, input bit [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input bit [15:0] a, output bit [31:0] da, output bit [31:0] db);
    addr = a; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("rd_vld_lit", 64'({a_dv, b_dv}), 64'(2'b11));
    da = a_rd;
    db = b_rd;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc();
    done = 1'b0;
  endtask

  bit [15:0] offs [0:13] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18,
                             16'h1C, 16'h20, 16'h24, 16'h30, 16'h26, 16'h02, 16'h40};

  initial begin
    bit [31:0] da, db;
    int w, d, s0, p0;

    rst_n = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;

    rd(16'h0000, da, db); chk("id", 64'({da, db}), {32'hA1B5_0001, 32'hA1B5_0001});
    rd(16'h0008, da, db); chk("num_pkts_rst", 64'(da), 64'(32'h0000_0010));
    rd(16'h0010, da, db); chk("status_rst", 64'(da), 64'(32'h0));

    wr(16'h000C, 32'h1234_5678);
    wr(16'h0004, 32'h6);
    rd(16'h000C, da, db); chk("seed_rb", 64'(da), 64'(32'h1234_5678));
    rd(16'h0004, da, db); chk("ctrl_rb", 64'(da), 64'(32'h6));
    chk("cfg_pins", 64'({a_seed, a_loop, a_cont}), {30'd0, 32'h1234_5678, 2'b11});

    // Normal run
    s0 = nstart;
    w = cycnum;
    wr(16'h0004, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tx = 1'b1; rx = (i < 4); err = (i == 0);
      cyc();
    end
    tx = 0; rx = 0; err = 0;
    for (int i = 0; i < 20; i++) cyc();
    d = cycnum;
    pulse_done();
    chk("start_once", 64'(nstart - s0), 64'd1);
    rd(16'h0010, da, db); chk("status_done", 64'(da), 64'(32'h6));
    rd(16'h0014, da, db); chk("tx_cnt", 64'(da), 64'(32'd5));
    rd(16'h0018, da, db); chk("rx_cnt", 64'(da), 64'(32'd4));
    rd(16'h001C, da, db); chk("err_cnt", 64'(da), 64'(32'd1));
    rd(16'h0020, da, db); chk("run_cycles", 64'({da, db}), {32'(d - w), 32'd15});

    // START while busy is ignored, then STOP
    s0 = nstart; p0 = nstop;
    wr(16'h0004, 32'h1);
    tx = 1; cyc(); cyc(); cyc(); tx = 0;
    wr(16'h0004, 32'h1);
    rd(16'h0014, da, db); chk("tx_busy_start", 64'(da), 64'(32'd3));
    chk("start_busy", 64'(nstart - s0), 64'd1);
    wr(16'h0004, 32'h8);
    cyc(); cyc();
    rd(16'h0010, da, db); chk("status_stopping", 64'(da), 64'(32'h5));
    chk("stop_once", 64'(nstop - p0), 64'd1);
    pulse_done();
    rd(16'h0010, da, db); chk("status_after_stop", 64'(da), 64'(32'h6));

    // Sticky set beats W1C
    wr(16'h0004, 32'h1);
    cyc(); cyc();
    addr = 16'h0010; wdata = 32'h2; wr_en = 1; done = 1;
    cyc();
    wr_en = 0; done = 0;
    rd(16'h0010, da, db); chk("sticky_vs_w1c", 64'(da), 64'(32'h6));
    wr(16'h0010, 32'h6);
    rd(16'h0010, da, db); chk("w1c_clear", 64'(da), 64'(32'h0));

    // Saturation on the narrow instance
    wr(16'h0004, 32'h1);
    tx = 1;
    for (int i = 0; i < 20; i++) cyc();
    tx = 0;
    rd(16'h0014, da, db); chk("tx_sat", 64'({da, db}), {32'd20, 32'd15});
    pulse_done();

    rd(16'h0030, da, db); chk("unmapped_30", 64'({da, db}), {32'hBADA_DD00, 32'hBADA_DD00});
    rd(16'h0026, da, db); chk("misaligned_26", 64'({da, db}), {32'hBADA_DD00, 32'hBADA_DD00});

    // Reset mid-run
    wr(16'h0004, 32'h1);
    tx = 1; rx = 1; cyc(); cyc(); tx = 0; rx = 0;
    rst_n = 0; cyc(); rst_n = 1;
    rd(16'h0010, da, db); chk("status_after_rst", 64'(da), 64'(32'h0));
    rd(16'h0014, da, db); chk("tx_after_rst", 64'({da, db}), 64'd0);
    rd(16'h0020, da, db); chk("run_after_rst", 64'(da), 64'(32'h0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      addr  = ($urandom_range(0, 19) == 0) ? 16'($urandom) : offs[$urandom_range(0, 13)];
      wr_en = ($urandom_range(0, 3) == 0);
      rd_en = $urandom_range(0, 1) != 0;
      wdata = $urandom;
      tx    = ($urandom_range(0, 2) == 0);
      rx    = ($urandom_range(0, 2) == 0);
      err   = ($urandom_range(0, 9) == 0);
      done  = ($urandom_range(0, 24) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cyc();
    end
    wr_en = 0; rd_en = 0; tx = 0; rx = 0; err = 0; done = 0; rst_n = 1;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axist_test_csr.md
Name: axist_test_csr

Overview:
- Register bank and test-run sequencer directly downstream of the JTAG-to-AVMM address decode stage.
- Consumes that stage's decoded 16-bit offset, write strobe, read strobe and write data. Returns read data with a valid flag.
- Drives the AXI4-ST traffic generator/checker: configuration, start/stop pulses. Collects packet/error events into status counters and a run-time counter.
- Offset 0x0030 (echo) is serviced upstream and never reaches this block; 0x0030 is left unmapped here.

Parameters:
- ID_VALUE, 32'hA1B5_0001, value returned by the ID register.
- CNT_W, 32, width of the event/cycle counters (1..32); zero-extended to 32 bits on readback.
- NUM_PKTS_RST, 16'd16, reset value of NUM_PKTS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wr_rd_addr  in  16  byte offset, word aligned.
- wr_en  in  1  write strobe; each high cycle is one write.
- rd_en  in  1  read strobe; each high cycle is one read.
- wr_data  in  32  write data.
- rd_datain  out  32  read data.
- rd_dvalid  out  1  read data valid.
- start_o  out  1  one-cycle run start pulse.
- stop_o  out  1  one-cycle run abort pulse.
- loopback_o  out  1  CTRL[1].
- cont_o  out  1  CTRL[2], continuous mode.
- num_pkts_o  out  16  NUM_PKTS.
- seed_o  out  32  PAT_SEED.
- tx_pkt_i  in  1  pulse per packet sent.
- rx_pkt_i  in  1  pulse per packet received.
- err_i  in  1  pulse per checker mismatch.
- done_i  in  1  pulse when the generator finishes or acknowledges a stop.

Behaviour:
- Reset clock and polarity: reset rst_n, synchronous, active-low; clock clk.
- Reset values:
  - rd_datain=0, rd_dvalid=0, start_o=0, stop_o=0.
  - CTRL=0, NUM_PKTS=NUM_PKTS_RST, PAT_SEED=0, SCRATCH=0.
  - All counters and sticky bits 0; FSM in IDLE.
- Read path, fixed 1-cycle latency:
  - rd_en in cycle N -> rd_dvalid=1 and rd_datain=reg value in N+1.
  - rd_en held high gives one result per cycle.
  - rd_dvalid=0 and rd_datain=0 when rd_en was low the previous cycle.
- Read and write same cycle: the read returns the pre-write value.
- Register map (offset: access, content):
  - 0x00 ID: RO, ID_VALUE.
  - 0x04 CTRL: RW. [0] START, write-1 pulse, reads 0. [1] loopback. [2] continuous. [3] STOP, write-1 pulse, reads 0. Other bits read 0.
  - 0x08 NUM_PKTS: RW, [15:0]; upper bits read 0.
  - 0x0C PAT_SEED: RW, 32 bits.
  - 0x10 STATUS: [0] busy (RO, FSM!=IDLE). [1] done, sticky, W1C. [2] err, sticky, W1C, set on any err_i.
  - 0x14 TX_CNT, 0x18 RX_CNT, 0x1C ERR_CNT: RO, saturating at 2^CNT_W-1.
  - 0x20 RUN_CYCLES: RO. Counts clk cycles while in RUN or STOPPING. Saturates. Freezes in IDLE.
  - 0x24 SCRATCH: RW, 32 bits.
- Unmapped or misaligned offsets (addr[1:0]!=0):
  - Read returns 32'hBADA_DD00 with rd_dvalid=1.
  - Write is ignored.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE + write CTRL[0]=1: start_o pulses the next cycle. TX/RX/ERR counters, RUN_CYCLES and STATUS[1] clear. -> RUN.
  - RUN + done_i: set STATUS[1] -> IDLE.
  - RUN + write CTRL[3]=1: stop_o pulses the next cycle -> STOPPING.
  - STOPPING + done_i: set STATUS[1] -> IDLE.
  - START while not IDLE is ignored; CTRL[1]/[2] still update.
  - STOP in IDLE or STOPPING is ignored.
  - START and STOP both set in one write from IDLE: START wins.
- Simultaneous events:
  - Event pulse in the same cycle as start-clear: clear wins, the pulse is dropped.
  - Sticky set and W1C in the same cycle: set wins.
  - done_i in the same cycle as a STOP write in RUN: go IDLE, no stop_o.
- Events outside RUN/STOPPING still increment the counters; only start clears them.
- Config outputs (loopback_o, cont_o, num_pkts_o, seed_o) are direct register outputs and are writable at any time.
- Reset asserted mid-run: immediate return to IDLE and reset values. No stop_o is issued.

Decomposition:
- Shared package axist_test_csr_pkg holds:
  - register offset localparams: ID, CTRL, NUM_PKTS, PAT_SEED, STATUS, TX_CNT, RX_CNT, ERR_CNT, RUN_CYCLES, SCRATCH;
  - CTRL and STATUS bit indices;
  - the unmapped-read constant 32'hBADA_DD00;
  - the FSM state enum.
- Sub-module: axist_sat_counter (CNT_W, inc, clr with clr priority, saturating). Instantiated four times (TX, RX, ERR, RUN_CYCLES).

Test Plan:
- Reset, then read 0x00, 0x08, 0x10 -> rd_dvalid one cycle after each rd_en; data A1B5_0001, 0000_0010, 0000_0000.
- Write 0x0C=1234_5678 and 0x04=6, read them back -> seed_o=1234_5678, loopback_o=1, cont_o=1; CTRL reads 6.
- Write 0x04=1; issue 5 tx_pkt_i, 4 rx_pkt_i, 1 err_i; wait 20 cycles; pulse done_i ->
  - start_o pulses once; STATUS reads 6 (busy=0, done=1, err=1);
  - TX_CNT=5, RX_CNT=4, ERR_CNT=1;
  - RUN_CYCLES equals the cycles from RUN entry to done_i.
- While busy, write CTRL=1 -> no start_o, counters unchanged. Then write CTRL=8 -> stop_o pulse, STATUS[0] stays 1 until done_i.
- Write STATUS=2 in the same cycle as done_i -> STATUS[1] remains 1. Write STATUS=6 alone -> reads 0.
- CNT_W=4: 20 tx_pkt_i -> TX_CNT=15. Read 0x30 and 0x26 -> BADA_DD00 with rd_dvalid=1. Reset mid-RUN -> busy=0, all counters 0.
